// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes,
// datapath mux selects and trap causes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEMADR   = 4'd3,
        ST_MEMREAD  = 4'd4,
        ST_MEMWB    = 4'd5,
        ST_MEMWRITE = 4'd6,
        ST_EXECUTE  = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_ADDIEXEC = 4'd10,
        ST_ADDIWB   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_TRAP     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef struct packed {
        logic       pc_en;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    // States that sit on the shared memory port waiting for mem_ready
    function automatic logic is_wait_state(state_t s);
        return (s == ST_FETCH) || (s == ST_MEMREAD) || (s == ST_MEMWRITE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles in a memory state; flags expiry when the limit is
// reached and memory is still not ready. TIMEOUT_CYCLES=0 never expires.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic waiting,
    input  logic mem_ready,
    output logic expired
);
    localparam int W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

    logic [W-1:0] cnt;

    // Saturates at LIMIT so a disabled or ignored expiry never wraps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (waiting && !mem_ready && cnt != LIMIT)
            cnt <= cnt + W'(1);
    end

    assign expired = (TIMEOUT_CYCLES > 0) && waiting && !mem_ready && (cnt == LIMIT);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/
// writeback, traps on illegal opcodes or memory timeout, counts retires.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic [3:0]       state_out,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);
    state_t           state_q, state_d;
    logic [1:0]       cause_q;
    logic [CNT_W-1:0] retired_q;
    logic             expired, clear_wait, retire_ev;
    ctrl_t            ctrl;

    mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear_wait),
        .waiting   (is_wait_state(state_q)),
        .mem_ready (mem_ready),
        .expired   (expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     state_d = ST_FETCH;
            ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
                         else if (expired) state_d = ST_TRAP;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_EXECUTE;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_ADDI:      state_d = ST_ADDIEXEC;
                    OP_J:         state_d = ST_JUMP;
                    default:      state_d = ST_TRAP;
                endcase
            end
            ST_MEMADR:   state_d = (opcode == OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD:  if (mem_ready) state_d = ST_MEMWB;
                         else if (expired) state_d = ST_TRAP;
            ST_MEMWRITE: if (mem_ready) state_d = ST_FETCH;
                         else if (expired) state_d = ST_TRAP;
            ST_MEMWB,
            ST_ALUWB,
            ST_BRANCH,
            ST_ADDIWB,
            ST_JUMP:     state_d = ST_FETCH;
            ST_EXECUTE:  state_d = ST_ALUWB;
            ST_ADDIEXEC: state_d = ST_ADDIWB;
            ST_TRAP:     state_d = ST_TRAP;
            default:     state_d = ST_IDLE;
        endcase
    end

    assign clear_wait = (state_d != state_q) && is_wait_state(state_d);
    assign retire_ev  = (state_d == ST_FETCH) &&
                        (state_q inside {ST_MEMWB, ST_MEMWRITE, ST_ALUWB,
                                         ST_BRANCH, ST_ADDIWB, ST_JUMP});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cause_q   <= CAUSE_NONE;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            // Only DECODE traps on opcode; every other trap source is a timeout
            if (state_q != ST_TRAP && state_d == ST_TRAP)
                cause_q <= (state_q == ST_DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
            if (retire_ev)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_en     = mem_ready;
            end
            ST_DECODE:   ctrl.alu_src_b = SRCB_IMM_SH2;
            ST_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            ST_MEMREAD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEMWRITE: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            ST_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.pc_en     = zero;
            end
            ST_ADDIEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            ST_ADDIWB:   ctrl.reg_write = 1'b1;
            ST_JUMP: begin
                ctrl.pc_src = PCSRC_JUMP;
                ctrl.pc_en  = 1'b1;
            end
            default:     ctrl = '0;
        endcase
    end

    assign pc_en      = ctrl.pc_en;
    assign ir_write   = ctrl.ir_write;
    assign iord       = ctrl.iord;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign reg_write  = ctrl.reg_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign pc_src     = ctrl.pc_src;
    assign state_out  = state_q;
    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = cause_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized instruction streams against a per-instruction phase plan built
// from the control table; plus directed trap, timeout and reset cases.
module tb_mips_multicycle_ctrl;
    localparam int TO = 15;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3,
                   S_MEMREAD = 4, S_MEMWB = 5, S_MEMWRITE = 6, S_EXEC = 7,
                   S_ALUWB = 8, S_BRANCH = 9, S_ADDIEX = 10, S_ADDIWB = 11,
                   S_JUMP = 12, S_TRAP = 15;

    localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011,
                           O_BEQ = 6'b000100, O_ADDI = 6'b001000, O_J = 6'b000010;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  opcode = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_en, ir_write, iord, mem_read, mem_write, reg_write;
    logic        reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_src, trap_cause;
    logic [3:0]  state_out;
    logic        trap;
    logic [31:0] retired;

    mips_multicycle_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .ir_write(ir_write),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .state_out(state_out), .trap(trap),
        .trap_cause(trap_cause), .retired(retired)
    );

    always #5 clk = ~clk;

    wire [14:0] ctrl_act = {pc_en, ir_write, iord, mem_read, mem_write, reg_write,
                            reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src};

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_ret = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Expected control word straight from the per-state output table
    function automatic logic [14:0] exp_ctrl(input int s, input logic rdy, input logic z);
        logic pe, irw, io, mr, mw, rw, rd, m2r, sa;
        logic [1:0] sb, ao, ps;
        {pe, irw, io, mr, mw, rw, rd, m2r, sa} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (s)
            S_FETCH:    begin mr = 1; sb = 2'b01; pe = rdy; irw = rdy; end
            S_DECODE:   sb = 2'b11;
            S_MEMADR:   begin sa = 1; sb = 2'b10; end
            S_MEMREAD:  begin io = 1; mr = 1; end
            S_MEMWB:    begin rw = 1; m2r = 1; end
            S_MEMWRITE: begin io = 1; mw = 1; end
            S_EXEC:     begin sa = 1; ao = 2'b10; end
            S_ALUWB:    begin rw = 1; rd = 1; end
            S_BRANCH:   begin sa = 1; ao = 2'b01; ps = 2'b01; pe = z; end
            S_ADDIEX:   begin sa = 1; sb = 2'b10; end
            S_ADDIWB:   rw = 1;
            S_JUMP:     begin ps = 2'b10; pe = 1; end
            default:    ;
        endcase
        return {pe, irw, io, mr, mw, rw, rd, m2r, sa, sb, ao, ps};
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {O_R, O_LW, O_SW, O_BEQ, O_ADDI, O_J};
    endfunction

    task automatic step(input logic rdy);
        @(posedge clk);
        #1 mem_ready = rdy;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mem_ready = 1'b0;
        exp_ret = '0;
        #1;
        chk("rst_state", 64'(state_out), 64'(S_IDLE));
        chk("rst_ctrl", 64'(ctrl_act), 64'(0));
        chk("rst_retired", 64'(retired), 64'(0));
        chk("rst_trap", 64'({trap, trap_cause}), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        #1 chk("idle_state", 64'(state_out), 64'(S_IDLE));
    endtask

    // Build the phase plan for one instruction, then walk it cycle by cycle
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input logic z);
        int   st[$];
        logic rd[$];
        for (int i = 0; i < wf; i++) begin st.push_back(S_FETCH); rd.push_back(1'b0); end
        st.push_back(S_FETCH);  rd.push_back(1'b1);
        st.push_back(S_DECODE); rd.push_back(1'($urandom_range(0, 1)));
        if (op == O_LW || op == O_SW) begin
            st.push_back(S_MEMADR); rd.push_back(1'($urandom_range(0, 1)));
            for (int i = 0; i < wm; i++) begin
                st.push_back(op == O_LW ? S_MEMREAD : S_MEMWRITE); rd.push_back(1'b0);
            end
            st.push_back(op == O_LW ? S_MEMREAD : S_MEMWRITE); rd.push_back(1'b1);
            if (op == O_LW) begin st.push_back(S_MEMWB); rd.push_back(1'($urandom_range(0, 1))); end
        end else if (op == O_R) begin
            st.push_back(S_EXEC);   rd.push_back(1'($urandom_range(0, 1)));
            st.push_back(S_ALUWB);  rd.push_back(1'($urandom_range(0, 1)));
        end else if (op == O_BEQ) begin
            st.push_back(S_BRANCH); rd.push_back(1'($urandom_range(0, 1)));
        end else if (op == O_ADDI) begin
            st.push_back(S_ADDIEX); rd.push_back(1'($urandom_range(0, 1)));
            st.push_back(S_ADDIWB); rd.push_back(1'($urandom_range(0, 1)));
        end else if (op == O_J) begin
            st.push_back(S_JUMP);   rd.push_back(1'($urandom_range(0, 1)));
        end
        opcode = op;
        zero   = z;
        for (int i = 0; i < st.size(); i++) begin
            step(rd[i]);
            chk("state", 64'(state_out), 64'(st[i]));
            chk("ctrl", 64'(ctrl_act), 64'(exp_ctrl(st[i], rd[i], z)));
            chk("retired", 64'(retired), 64'(exp_ret));
            chk("trap_low", 64'(trap), 64'(0));
        end
        if (is_legal(op)) begin
            exp_ret = exp_ret + 32'd1;
        end else begin
            for (int i = 0; i < 20; i++) begin
                zero = 1'($urandom_range(0, 1));
                step(1'($urandom_range(0, 1)));
                chk("trap_state", 64'(state_out), 64'(S_TRAP));
                chk("trap_flag", 64'({trap, trap_cause}), 64'(3'b101));
                chk("trap_ctrl", 64'(ctrl_act), 64'(0));
                chk("trap_retired", 64'(retired), 64'(exp_ret));
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] legal_ops [6];
        logic [5:0] op;
        legal_ops = '{O_R, O_LW, O_SW, O_BEQ, O_ADDI, O_J};

        do_reset();
        run_instr(O_R, 0, 0, 1'b0);
        run_instr(O_LW, 0, 3, 1'b0);
        run_instr(O_BEQ, 0, 0, 1'b1);
        run_instr(O_BEQ, 0, 0, 1'b0);
        run_instr(O_J, 0, 0, 1'b0);
        run_instr(O_SW, TO, TO, 1'b0);
        step(1'b0);
        chk("retired_after_dir", 64'(retired), 64'(exp_ret));

        do_reset();
        for (int n = 0; n < 60; n++) begin
            op = legal_ops[$urandom_range(0, 5)];
            run_instr(op, (n % 4 == 0) ? $urandom_range(0, TO) : $urandom_range(0, 2),
                       $urandom_range(0, TO), 1'($urandom_range(0, 1)));
        end
        step(1'b0);
        chk("retired_after_rand", 64'(retired), 64'(exp_ret));

        do_reset();
        run_instr(O_ADDI, 0, 0, 1'b0);
        do op = 6'($urandom_range(0, 63)); while (is_legal(op));
        run_instr(op, 1, 0, 1'b0);
        do_reset();
        run_instr(6'b111111, 0, 0, 1'b0);
        do_reset();

        // FETCH timeout: 16 stalled cycles then TRAP with timeout cause
        opcode = O_R;
        for (int i = 0; i < TO + 1; i++) begin
            step(1'b0);
            chk("to_fetch_state", 64'(state_out), 64'(S_FETCH));
            chk("to_fetch_ctrl", 64'(ctrl_act), 64'(exp_ctrl(S_FETCH, 1'b0, 1'b0)));
        end
        step(1'b1);
        chk("to_trap_state", 64'(state_out), 64'(S_TRAP));
        chk("to_trap_flag", 64'({trap, trap_cause}), 64'(3'b110));
        step(1'b1);
        chk("to_trap_sticky", 64'(state_out), 64'(S_TRAP));

        // MEMREAD timeout after a retired instruction
        do_reset();
        run_instr(O_J, 0, 0, 1'b0);
        opcode = O_LW;
        step(1'b1); step(1'b0); step(1'b0);
        chk("tor_memadr", 64'(state_out), 64'(S_MEMADR));
        for (int i = 0; i < TO + 1; i++) begin
            step(1'b0);
            chk("tor_memread", 64'(state_out), 64'(S_MEMREAD));
        end
        step(1'b0);
        chk("tor_trap", 64'({state_out, trap, trap_cause}), 64'({4'd15, 3'b110}));
        chk("tor_retired", 64'(retired), 64'(1));

        // Asynchronous reset in the middle of a store
        do_reset();
        run_instr(O_R, 0, 0, 1'b0);
        opcode = O_SW;
        step(1'b1); step(1'b0); step(1'b0); step(1'b0);
        chk("mw_state", 64'(state_out), 64'(S_MEMWRITE));
        chk("mw_strobe", 64'(mem_write), 64'(1));
        #1 reset = 1'b0;
        #1;
        chk("mw_abort_strobe", 64'(mem_write), 64'(0));
        chk("mw_abort_state", 64'(state_out), 64'(S_IDLE));
        chk("mw_abort_retired", 64'(retired), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        exp_ret = '0;
        run_instr(O_ADDI, 2, 0, 1'b0);
        step(1'b0);
        chk("final_retired", 64'(retired), 64'(exp_ret));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle control FSM that sequences the MIPS datapath: PC, register file, ALU, shared instruction/data memory port.
- Decodes the latched opcode and steps fetch/decode/execute/memory/writeback, one state per cycle.
- Memory states use a ready handshake and a timeout. The block traps on illegal opcodes and counts retired instructions.

Parameters:
- TIMEOUT_CYCLES, 15: maximum cycles a memory state may wait for mem_ready; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- opcode  in  6  instr[31:26] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_en  out  1  PC load enable.
- ir_write  out  1  instruction register load.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  destination register: 1=rd, 0=rt.
- mem_to_reg  out  1  writeback data: 1=memory, 0=ALUOut.
- alu_src_a  out  1  ALU A input: 0=PC, 1=rs data.
- alu_src_b  out  2  ALU B input: 00=rt data, 01=constant 4, 10=sign_imm, 11=sign_imm<<2.
- alu_op  out  2  00=add, 01=sub, 10=decode by funct.
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- state_out  out  4  current state encoding.
- trap  out  1  high while in TRAP.
- trap_cause  out  2  01=illegal opcode, 10=memory timeout; 00 otherwise.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXECUTE=7, ALUWB=8, BRANCH=9, ADDIEXEC=10, ADDIWB=11, JUMP=12, TRAP=15.
- Reset (reset=0, asynchronous): state=IDLE, retired=0, trap_cause=00, wait counter=0. In IDLE every output is 0.
  - Reset asserted mid-instruction aborts that instruction; no partial retire.
- Control outputs are a combinational decode of state. Any output not listed for a state is 0.
- IDLE -> FETCH unconditionally.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write=1 and pc_en=1 only in the cycle mem_ready=1; the FSM then goes to DECODE. Otherwise it stays in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR.
  - 000000 (R-type) -> EXECUTE.
  - 000100 (beq) -> BRANCH.
  - 001000 (addi) -> ADDIEXEC.
  - 000010 (j) -> JUMP.
  - any other opcode -> TRAP, cause 01.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: iord=1, mem_read=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEMWRITE: iord=1, mem_write=1, held until mem_ready. Then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Then ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero. Then FETCH.
- ADDIEXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Then ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
- JUMP: pc_src=10, pc_en=1. Then FETCH.
- Wait counter:
  - Cleared on entry to FETCH, MEMREAD or MEMWRITE.
  - Increments each cycle in that state with mem_ready=0.
  - If TIMEOUT_CYCLES>0 and the counter equals TIMEOUT_CYCLES with mem_ready=0: next state TRAP, cause 10.
  - mem_ready=1 in that same cycle wins over the timeout.
- TRAP: sticky until reset. trap=1, all strobes 0, retired frozen.
- retired increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB or JUMP. It wraps modulo 2^CNT_W.
- Instruction latencies from FETCH entry with zero wait states:
  - lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - the state enum (4-bit);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - alu_src_b, pc_src and alu_op encodings;
  - trap cause codes.
- One sub-module, mem_wait_timer: wait counter plus timeout compare, with inputs clear, waiting, mem_ready and output expired.

Test Plan:
- Reset release, mem_ready tied 1, opcode=000000 -> state sequence 0,1,2,7,8,1. ir_write and pc_en high in cycle 1, reg_write=1 and reg_dst=1 in ALUWB, retired=1.
- lw (100011) with mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles, iord=1 throughout. MEMWB asserts reg_write=1 and mem_to_reg=1; retired increments once.
- beq (000100) with zero=1, then a second beq with zero=0 -> pc_en=1 and pc_src=01 in BRANCH for the first; pc_en=0 for the second. Both retire, retired=2.
- Opcode 111111 in DECODE -> TRAP, trap=1, trap_cause=01. Outputs stay frozen for 20 cycles; reset=0 returns to IDLE with retired=0.
- TIMEOUT_CYCLES=15, mem_ready held 0 in FETCH -> TRAP after 16 FETCH cycles, trap_cause=10. Repeat with mem_ready=1 on the 16th cycle -> DECODE, no trap.
- reset pulsed low during MEMWRITE -> mem_write drops to 0 immediately (asynchronously), state=0, no retire counted.
